// File: rtl/dskw_frame_ctrl.sv
// Frame sequencer around the Deskew engine: loads one image into BRAM port A,
// starts Deskew, waits for completion, then streams the result out.
module dskw_frame_ctrl #(
    parameter int WIDTH      = 16,
    parameter int ADDR_W     = 11,
    parameter int IMG_PIXELS = 784,
    parameter int OUT_BASE   = 784
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    input  logic [WIDTH-1:0]  s_data,
    output logic              s_ready,
    input  logic              s_last,
    output logic              dskw_start,
    input  logic              dskw_ready,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [WIDTH-1:0]  bram_wdata,
    input  logic [WIDTH-1:0]  bram_rdata,
    output logic              m_valid,
    output logic [WIDTH-1:0]  m_data,
    output logic              m_last,
    input  logic              m_ready,
    output logic              busy,
    output logic              frame_done,
    output logic              len_err
);

    localparam int               CNT_W    = $clog2(IMG_PIXELS + 1);
    localparam logic [CNT_W-1:0] NPIX     = CNT_W'(IMG_PIXELS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(IMG_PIXELS - 1);

    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] load_cnt;
    logic [CNT_W-1:0] rd_cnt;
    logic [CNT_W-1:0] out_cnt;

    logic [WIDTH-1:0] fifo_mem [2];
    logic             fifo_rd_ptr;
    logic             fifo_wr_ptr;
    logic [1:0]       fifo_count;
    logic             inflight;

    logic             beat;
    logic             pop;
    logic             push;
    logic             rd_issue;
    logic [2:0]       occupancy;

    always_comb begin
        s_ready    = (state == ST_LOAD) && !reset;
        beat       = s_valid && s_ready;
        m_valid    = (fifo_count != 2'd0);
        pop        = m_valid && m_ready;
        push       = inflight;
        occupancy  = {1'b0, fifo_count} + {2'b00, inflight};
        // A same-cycle pop frees a slot, so it is credited to keep 1 pixel/clk.
        rd_issue   = (state == ST_DRAIN) && (rd_cnt < NPIX) &&
                     (occupancy <= (3'd1 + {2'b00, pop}));

        bram_en    = beat || rd_issue;
        bram_we    = beat;
        bram_wdata = beat ? s_data : '0;
        if (beat)
            bram_addr = ADDR_W'(load_cnt);
        else if (rd_issue)
            bram_addr = ADDR_W'(OUT_BASE) + ADDR_W'(rd_cnt);
        else
            bram_addr = '0;

        dskw_start = (state == ST_START);
        m_data     = m_valid ? fifo_mem[fifo_rd_ptr] : '0;
        m_last     = m_valid && (out_cnt == LAST_IDX);
        busy       = !reset && !((state == ST_LOAD) && (load_cnt == '0));
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[fifo_wr_ptr] <= bram_rdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_LOAD;
            load_cnt    <= '0;
            rd_cnt      <= '0;
            out_cnt     <= '0;
            fifo_rd_ptr <= 1'b0;
            fifo_wr_ptr <= 1'b0;
            fifo_count  <= 2'd0;
            inflight    <= 1'b0;
            frame_done  <= 1'b0;
            len_err     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            inflight   <= rd_issue;

            if (push)
                fifo_wr_ptr <= ~fifo_wr_ptr;
            if (pop)
                fifo_rd_ptr <= ~fifo_rd_ptr;
            if (push && !pop)
                fifo_count <= fifo_count + 2'd1;
            else if (pop && !push)
                fifo_count <= fifo_count - 2'd1;

            case (state)
                ST_LOAD: begin
                    if (beat) begin
                        if (s_last != (load_cnt == LAST_IDX))
                            len_err <= 1'b1;
                        if (load_cnt == LAST_IDX) begin
                            load_cnt <= '0;
                            state    <= ST_START;
                        end else begin
                            load_cnt <= load_cnt + 1'b1;
                        end
                    end
                end
                ST_START: begin
                    if (!dskw_ready)
                        state <= ST_RUN;
                end
                ST_RUN: begin
                    if (dskw_ready)
                        state <= ST_DRAIN;
                end
                default: begin
                    if (rd_issue)
                        rd_cnt <= rd_cnt + 1'b1;
                    if (pop) begin
                        if (out_cnt == LAST_IDX) begin
                            out_cnt    <= '0;
                            rd_cnt     <= '0;
                            frame_done <= 1'b1;
                            state      <= ST_LOAD;
                        end else begin
                            out_cnt <= out_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dskw_frame_ctrl.sv
// Self-checking bench for dskw_frame_ctrl: BRAM and Deskew behavioural models,
// random handshakes, expected output derived from the pixels the bench sent.
module tb_dskw_frame_ctrl;

    localparam int NPIX = 784;
    localparam int OUTB = 784;

    logic        clk = 1'b0;
    logic        reset;
    logic        s_valid;
    logic [15:0] s_data;
    logic        s_ready;
    logic        s_last;
    logic        dskw_start;
    logic        dskw_ready;
    logic        bram_en;
    logic        bram_we;
    logic [10:0] bram_addr;
    logic [15:0] bram_wdata;
    logic [15:0] bram_rdata;
    logic        m_valid;
    logic [15:0] m_data;
    logic        m_last;
    logic        m_ready;
    logic        busy;
    logic        frame_done;
    logic        len_err;

    int total = 0;
    int bad   = 0;
    int hi_wr = 0;

    logic [15:0] bram_mem [2048];
    logic [15:0] sent     [NPIX];
    logic [15:0] ref_out  [NPIX];

    dskw_frame_ctrl #(
        .WIDTH(16), .ADDR_W(11), .IMG_PIXELS(NPIX), .OUT_BASE(OUTB)
    ) dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .s_last(s_last),
        .dskw_start(dskw_start), .dskw_ready(dskw_ready),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_wdata(bram_wdata), .bram_rdata(bram_rdata),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
        .busy(busy), .frame_done(frame_done), .len_err(len_err)
    );

    always #5 clk = ~clk;

    // Port A of the shared BRAM, read-first, 1-cycle read latency
    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_we)
                bram_mem[bram_addr] <= bram_wdata;
            bram_rdata <= bram_mem[bram_addr];
        end
    end

    always @(negedge clk) begin
        if (!reset && bram_en && bram_we && bram_addr >= 11'(OUTB))
            hi_wr++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Ends on the negedge where dskw_start is first expected high
    task automatic load_frame(input int gaps, input int bad_at);
        int idx = 0, cyc = 0, wr_err = 0, idle_err = 0, busy_err = 0;
        logic pre_err = 1'b0, mid_err = 1'b0;
        bit mid_done = 0;
        while (idx < NPIX && cyc < 10000) begin
            @(negedge clk);
            cyc++;
            if (idx == bad_at) pre_err = len_err;
            if (idx == bad_at + 1 && !mid_done) begin
                mid_err  = len_err;
                mid_done = 1;
            end
            if (busy !== (idx != 0)) busy_err++;
            s_valid = (gaps == 0) || ($urandom_range(0, 1) == 1);
            s_data  = s_valid ? sent[idx] : 16'($urandom);
            s_last  = s_valid && ((bad_at >= 0) ? (idx == bad_at) : (idx == NPIX - 1));
            #1;
            if (s_valid) begin
                if (!(s_ready && bram_en && bram_we && bram_addr == 11'(idx) &&
                      bram_wdata == sent[idx]))
                    wr_err++;
                idx++;
            end else if (bram_en) begin
                idle_err++;
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk("ld_beats", idx, NPIX);
        chk("ld_writes", wr_err, 0);
        chk("ld_idle_en", idle_err, 0);
        chk("ld_busy", busy_err, 0);
        chk("start_rise", dskw_start, 1);
        chk("start_no_sready", s_ready, 0);
        if (bad_at >= 0) begin
            chk("len_err_pre", pre_err, 0);
            chk("len_err_mid", mid_err, 1);
        end
        chk("len_err_end", len_err, (bad_at >= 0) ? 1 : 0);
    endtask

    // Deskew engine: accepts start after drop_after cycles, busy for run_cycles
    task automatic deskew(input int drop_after, input int run_cycles, input int xform);
        int cnt = dskw_start ? 1 : 0;
        int guard = 0, porta_err = 0;
        while (guard < 100) begin
            if (cnt == drop_after && dskw_ready) dskw_ready = 1'b0;
            @(negedge clk);
            guard++;
            if (dskw_start) cnt++;
            else break;
        end
        chk("start_cycles", cnt, drop_after);
        for (int i = 0; i < NPIX; i++)
            bram_mem[OUTB + i] <= (xform == 0) ? 16'(16'h4000 + i) : (bram_mem[NPIX - 1 - i] ^ 16'hA5C3);
        repeat (run_cycles) begin
            @(negedge clk);
            if (bram_en || dskw_start) porta_err++;
        end
        chk("porta_idle", porta_err, 0);
        for (int i = 0; i < NPIX; i++)
            ref_out[i] = (xform == 0) ? 16'(16'h4000 + i) : (sent[NPIX - 1 - i] ^ 16'hA5C3);
        dskw_ready = 1'b1;
    endtask

    task automatic readout(input int rand_ready, input int abort_at);
        int idx = 0, cyc = 0, first = -1;
        int data_err = 0, last_err = 0, stall_err = 0, gap_err = 0, early_done = 0;
        bit prev_stall = 0, aborted = 0;
        logic [15:0] prev_data = '0;
        while (idx < NPIX && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (abort_at >= 0 && idx == abort_at) begin
                aborted = 1;
                break;
            end
            if (frame_done) early_done++;
            if (m_valid && first < 0) first = cyc;
            if (prev_stall && (!m_valid || m_data !== prev_data)) stall_err++;
            if (rand_ready == 0 && first >= 0 && !m_valid) gap_err++;
            m_ready = (rand_ready == 0) || ($urandom_range(0, 1) == 1);
            if (m_valid && m_ready) begin
                if (m_data !== ref_out[idx]) data_err++;
                if (m_last !== (idx == NPIX - 1)) last_err++;
                idx++;
                prev_stall = 0;
            end else begin
                prev_stall = m_valid;
                prev_data  = m_data;
            end
        end
        if (aborted) begin
            reset = 1'b1;
            @(negedge clk);
            chk("abort_outs_zero", |{s_ready, dskw_start, bram_en, bram_we, bram_addr, bram_wdata,
                                     m_valid, m_data, m_last, busy, frame_done, len_err}, 0);
            reset   = 1'b0;
            m_ready = 1'b0;
            #1;
            chk("abort_load_sready", s_ready, 1);
            chk("abort_load_busy", busy, 0);
        end else begin
            chk("first_valid_lat", first, 3);
            chk("out_count", idx, NPIX);
            chk("out_data", data_err, 0);
            chk("out_last", last_err, 0);
            chk("out_stall", stall_err, 0);
            if (rand_ready == 0) chk("out_gaps", gap_err, 0);
            chk("done_early", early_done, 0);
            @(negedge clk);
            m_ready = 1'b0;
            chk("frame_done", frame_done, 1);
            chk("sready_after", s_ready, 1);
            chk("mvalid_after", m_valid, 0);
            @(negedge clk);
            chk("frame_done_pulse", frame_done, 0);
        end
    endtask

    initial begin
        reset      = 1'b1;
        s_valid    = 1'b0;
        s_data     = '0;
        s_last     = 1'b0;
        dskw_ready = 1'b1;
        m_ready    = 1'b0;
        for (int i = 0; i < 2048; i++) bram_mem[i] <= 16'($urandom);

        @(negedge clk);
        chk("reset_outs_zero", |{s_ready, dskw_start, bram_en, bram_we, bram_addr, bram_wdata,
                                 m_valid, m_data, m_last, busy, frame_done, len_err}, 0);
        reset = 1'b0;
        #1;
        chk("idle_sready", s_ready, 1);
        chk("idle_busy", busy, 0);

        // Frame 1: ramp image, preloaded result, m_ready held high
        for (int i = 0; i < NPIX; i++) sent[i] = 16'(i);
        load_frame(0, -1);
        deskew(3, 500, 0);
        readout(0, -1);

        // Frame 2: random image with input gaps, random output backpressure
        for (int i = 0; i < NPIX; i++) sent[i] = 16'($urandom);
        load_frame(1, -1);
        deskew($urandom_range(1, 6), 40, 1);
        readout(1, -1);

        // Frame 3: early s_last, then reset in the middle of readout
        for (int i = 0; i < NPIX; i++) sent[i] = 16'($urandom);
        load_frame(0, 500);
        deskew(3, 30, 1);
        readout(1, 300);

        // Frame 4: full frame after the abort
        for (int i = 0; i < NPIX; i++) sent[i] = 16'($urandom);
        load_frame(1, -1);
        deskew(2, 25, 1);
        readout(0, -1);

        chk("no_high_writes", hi_wr, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
